tt_cnt_bus_ctrl: RTL and testbench

Command-driven controller for the test counter and the shared 8-bit `uio` bus in a Tiny Tapeout user tile. Accepts strobed 7-bit commands on `ui_in`, and sequences counter load/run/stop. Arbitrates `uio` direction with enforced turnaround cycles, so the pad driver and the external device never drive simultaneously. Sits between the tile pins and the counter datapath.

---
 rtl/tt_cnt_bus_ctrl_pkg.sv | 36 +++
 rtl/tt_sync_edge.sv | 29 ++
 rtl/tt_cnt_bus_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tt_cnt_bus_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_cnt_bus_ctrl_pkg.sv
// Shared constants and types for the counter / uio bus controller.
package tt_cnt_bus_ctrl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ARG_W  = 4;
  localparam int unsigned TURN_W = 4;

  localparam logic [OP_W-1:0] OP_VIEW   = 3'd0;
  localparam logic [OP_W-1:0] OP_LDL    = 3'd1;
  localparam logic [OP_W-1:0] OP_LDH    = 3'd2;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'd3;
  localparam logic [OP_W-1:0] OP_RUN    = 3'd4;
  localparam logic [OP_W-1:0] OP_STOP   = 3'd5;
  localparam logic [OP_W-1:0] OP_DRIVE  = 3'd6;
  localparam logic [OP_W-1:0] OP_SAMPLE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // Bit positions inside the status view on uo_out
  localparam int unsigned STAT_STROBE = 0;
  localparam int unsigned STAT_RUN    = 4;
  localparam int unsigned STAT_DIR    = 5;
  localparam int unsigned STAT_ERR    = 6;
  localparam int unsigned STAT_BUSY   = 7;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

endpackage

// File: rtl/tt_sync_edge.sv
// Multi-flop synchroniser with rising-edge detect for an asynchronous level.
module tt_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Flops reset high so a level already high at reset release needs a fresh rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/tt_cnt_bus_ctrl.sv
// Command-driven counter sequencer with turnaround-safe uio bus direction control.
module tt_cnt_bus_ctrl
  import tt_cnt_bus_ctrl_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [DATA_W-1:0] uio_in,
  output logic [DATA_W-1:0] uo_out,
  output logic [DATA_W-1:0] uio_out,
  output logic [DATA_W-1:0] uio_oe
);

  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_ok;
  logic                   strb_q;
  logic                   accept_c;
  logic                   unused_ok;
  cmd_t                   cmd_c;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   ld_q, ld_d;
  logic [ARG_W-1:0]    step_q, step_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic                view_q, view_d;
  logic                cap_q, cap_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [DATA_W-1:0]   status_c;
  logic [DATA_W-1:0]   uo_out_d, uio_out_d, uio_oe_d;

  assign unused_ok = ena;
  assign cmd_c     = cmd_t'(ui_in[6:0]);
  assign rst_ok    = rst_sync_q[SYNC_STAGES-1];

  // Reset release synchroniser; assertion stays asynchronous
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  tt_sync_edge #(.STAGES(SYNC_STAGES)) u_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ui_in[7]),
    .q      (strb_q),
    .rise_c (accept_c)
  );

  // Next-state: counting, turnaround sequencing and command decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ld_d     = ld_q;
    step_d   = step_q;
    dir_d    = dir_q;
    err_d    = err_q;
    view_d   = view_q;
    cap_d    = cap_q;
    turn_d   = turn_q;
    status_c = '0;

    if (state_q == ST_RUN) cnt_d = cnt_q + DATA_W'(step_q);

    if (state_q == ST_TURN) begin
      if (turn_q == '0) begin
        state_d = ST_IDLE;
        cap_d   = 1'b0;
        if (cap_q) cnt_d = uio_in;
        else       dir_d = 1'b1;
      end else begin
        turn_d = turn_q - TURN_W'(1);
      end
      if (accept_c) err_d = 1'b1;
    end else if (accept_c) begin
      case (cmd_c.op)
        OP_VIEW: begin
          view_d = cmd_c.arg[0];
          err_d  = 1'b0;
        end
        OP_LDL:  ld_d[3:0] = cmd_c.arg;
        OP_LDH:  ld_d[7:4] = cmd_c.arg;
        OP_LOAD: cnt_d = ld_q;
        OP_RUN: begin
          step_d  = cmd_c.arg;
          state_d = ST_RUN;
        end
        OP_STOP: begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
        OP_DRIVE: begin
          if (!dir_q) begin
            state_d = ST_TURN;
            turn_d  = TURN_LAST;
            cap_d   = 1'b0;
            cnt_d   = cnt_q;
          end
        end
        OP_SAMPLE: begin
          if (!dir_q) begin
            cnt_d   = uio_in;
            state_d = ST_IDLE;
          end else begin
            dir_d   = 1'b0;
            state_d = ST_TURN;
            turn_d  = TURN_LAST;
            cap_d   = 1'b1;
            cnt_d   = cnt_q;
          end
        end
        default: ;
      endcase
    end

    // Hold everything at reset values until reset release has synchronised
    if (!rst_ok) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ld_d    = '0;
      step_d  = '0;
      dir_d   = 1'b0;
      err_d   = 1'b0;
      view_d  = 1'b0;
      cap_d   = 1'b0;
      turn_d  = '0;
    end

    // Status word is a snapshot of the flags as they stood before this edge,
    // so a VIEW 1 still reports the err it clears
    status_c[STAT_BUSY]   = (state_q == ST_TURN);
    status_c[STAT_ERR]    = err_q;
    status_c[STAT_DIR]    = dir_q;
    status_c[STAT_RUN]    = (state_q == ST_RUN);
    status_c[STAT_STROBE] = strb_q;

    uo_out_d  = view_d ? status_c : cnt_d;
    uio_out_d = dir_d ? cnt_d : '0;
    uio_oe_d  = {DATA_W{dir_d}};
    if (!rst_ok) uo_out_d = '0;
  end

  // State and registered pin outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ld_q    <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      view_q  <= 1'b0;
      cap_q   <= 1'b0;
      turn_q  <= '0;
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      view_q  <= view_d;
      cap_q   <= cap_d;
      turn_q  <= turn_d;
      uo_out  <= uo_out_d;
      uio_out <= uio_out_d;
      uio_oe  <= uio_oe_d;
    end
  end

endmodule

// File: tb/tb_tt_cnt_bus_ctrl.sv
// Self-checking bench for tt_cnt_bus_ctrl with a cycle-indexed reference model.
module tb_tt_cnt_bus_ctrl;

  localparam int TURN = 2;
  localparam int SYNC = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena   = 1'b1;
  logic [7:0] ui_in  = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: counter value is base + elapsed_cycles * step while running
  logic [7:0] m_base = 8'h00;
  logic [7:0] m_ld   = 8'h00;
  logic [3:0] m_step = 4'h0;
  int         m_bcyc = 0;
  bit         m_run  = 1'b0;
  bit         m_dir  = 1'b0;
  bit         m_err  = 1'b0;
  bit         m_view = 1'b0;

  tt_cnt_bus_ctrl #(.TURN_CYCLES(TURN), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] cnt_at(input int c);
    if (m_run) return 8'(int'(m_base) + (c - m_bcyc) * int'(m_step));
    return m_base;
  endfunction

  function automatic logic [7:0] exp_uo(input int c);
    if (m_view) return {1'b0, m_err, m_dir, m_run, 4'b0000};
    return cnt_at(c);
  endfunction

  task automatic model_reset();
    m_base = 8'h00; m_ld = 8'h00; m_step = 4'h0; m_bcyc = cyc;
    m_run = 0; m_dir = 0; m_err = 0; m_view = 0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [3:0] arg, input int ca);
    case (op)
      3'd0: begin m_view = arg[0]; m_err = 0; end
      3'd1: m_ld[3:0] = arg;
      3'd2: m_ld[7:4] = arg;
      3'd3: begin m_base = m_ld; m_bcyc = ca; end
      3'd4: begin m_base = cnt_at(ca); m_bcyc = ca; m_step = arg; m_run = 1; end
      3'd5: begin m_base = cnt_at(ca - 1); m_run = 0; end
      3'd6: if (!m_dir) begin m_base = cnt_at(ca - 1); m_run = 0; m_dir = 1; end
      default: begin m_base = uio_in; m_run = 0; m_dir = 0; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic gap();
    repeat (SYNC + 1) tick();
  endtask

  // Raise strobe, return just after the accept edge with strobe dropped
  task automatic issue(input logic [2:0] op, input logic [3:0] arg, output int ca);
    ui_in = {1'b1, op, arg};
    repeat (SYNC + 1) tick();
    ca = cyc;
    model_cmd(op, arg, ca);
    ui_in[7] = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    ui_in = 8'hFF;
    uio_in = 8'h00;
    repeat (3) tick();
    n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo: got %h expected 00", uo_out); end
    n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h expected 00", uio_out); end
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL reset_uio_oe: got %h expected 00", uio_oe); end
    rst_n = 1'b1;
    repeat (6) tick();
    n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL release_uo: got %h expected 00", uo_out); end
    n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL release_uio_out: got %h expected 00", uio_out); end
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL release_uio_oe: got %h expected 00", uio_oe); end
    ui_in = 8'h00;
    gap();
    model_reset();
  endtask

  task automatic test_load_run_wrap();
    int ca;
    issue(3'd1, 4'hE, ca); gap();
    issue(3'd2, 4'hF, ca); gap();
    issue(3'd3, 4'h0, ca); gap();
    n_tests++; if (uo_out !== 8'hFE) begin n_fail++; $display("FAIL load_fe: got %h expected fe", uo_out); end
    issue(3'd4, 4'd3, ca);
    n_tests++; if (uo_out !== 8'hFE) begin n_fail++; $display("FAIL run_A: got %h expected fe", uo_out); end
    tick();
    n_tests++; if (uo_out !== 8'h01) begin n_fail++; $display("FAIL run_A1_wrap: got %h expected 01", uo_out); end
    tick();
    n_tests++; if (uo_out !== 8'h04) begin n_fail++; $display("FAIL run_A2: got %h expected 04", uo_out); end
    gap();
    issue(3'd5, 4'h0, ca); gap();
    n_tests++; if (uo_out !== cnt_at(cyc)) begin n_fail++; $display("FAIL stop_hold: got %h expected %h", uo_out, cnt_at(cyc)); end
  endtask

  task automatic test_drive();
    int ca;
    uio_in = 8'h33;
    issue(3'd6, 4'h0, ca);
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL drive_A: got %h expected 00", uio_oe); end
    tick();
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL drive_A1: got %h expected 00", uio_oe); end
    tick();
    n_tests++; if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL drive_A2: got %h expected ff", uio_oe); end
    n_tests++; if (uio_out !== cnt_at(cyc)) begin n_fail++; $display("FAIL drive_data: got %h expected %h", uio_out, cnt_at(cyc)); end
    gap();
  endtask

  task automatic test_sample();
    int ca;
    logic [7:0] old;
    old = cnt_at(cyc);
    uio_in = 8'h5A;
    issue(3'd7, 4'h0, ca);
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL sample_oe_A: got %h expected 00", uio_oe); end
    n_tests++; if (uo_out !== old) begin n_fail++; $display("FAIL sample_hold_A: got %h expected %h", uo_out, old); end
    tick(); tick();
    n_tests++; if (uo_out !== 8'h5A) begin n_fail++; $display("FAIL sample_cap: got %h expected 5a", uo_out); end
    gap();
    issue(3'd0, 4'h1, ca); gap();
    n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL sample_idle_status: got %h expected 00", uo_out); end
    issue(3'd0, 4'h0, ca); gap();
  endtask

  task automatic test_back_to_back_collision();
    int ca;
    logic [7:0] old;
    old = cnt_at(cyc);
    ui_in = {1'b1, 3'd6, 4'h0}; tick();
    ui_in[7] = 1'b0; tick();
    ui_in[7] = 1'b1; tick();
    ui_in[6:0] = {3'd3, 4'h0};
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL coll_turn_oe: got %h expected 00", uio_oe); end
    tick(); tick();
    ui_in[7] = 1'b0;
    m_dir = 1; m_err = 1;
    n_tests++; if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL coll_drive_done: got %h expected ff", uio_oe); end
    n_tests++; if (uo_out !== old) begin n_fail++; $display("FAIL coll_load_ignored: got %h expected %h", uo_out, old); end
    gap();
    issue(3'd0, 4'h1, ca);
    n_tests++; if (uo_out !== 8'h61) begin n_fail++; $display("FAIL coll_err_seen: got %h expected 61", uo_out); end
    gap();
    n_tests++; if (uo_out !== 8'h20) begin n_fail++; $display("FAIL coll_err_cleared: got %h expected 20", uo_out); end
    issue(3'd0, 4'h0, ca); gap();
    n_tests++; if (uo_out !== old) begin n_fail++; $display("FAIL coll_view0: got %h expected %h", uo_out, old); end
  endtask

  task automatic test_random();
    int ca;
    logic [2:0] op;
    logic [3:0] arg;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      arg = 4'($urandom);
      if (op == 3'd6 && m_dir && m_run) op = 3'd5;
      uio_in = 8'($urandom);
      issue(op, arg, ca);
      gap();
      n_tests++; if (uo_out !== exp_uo(cyc)) begin n_fail++; $display("FAIL rand_uo[%0d] op%0d: got %h expected %h", i, op, uo_out, exp_uo(cyc)); end
      n_tests++; if (uio_oe !== {8{m_dir}}) begin n_fail++; $display("FAIL rand_oe[%0d] op%0d: got %h expected %h", i, op, uio_oe, {8{m_dir}}); end
      n_tests++; if (uio_out !== (m_dir ? cnt_at(cyc) : 8'h00)) begin n_fail++; $display("FAIL rand_uio_out[%0d] op%0d: got %h expected %h", i, op, uio_out, (m_dir ? cnt_at(cyc) : 8'h00)); end
    end
  endtask

  task automatic test_reset_mid_run();
    int ca;
    if (!m_dir) begin issue(3'd6, 4'h0, ca); gap(); end
    issue(3'd4, 4'd5, ca); gap();
    n_tests++; if (uio_oe !== 8'hFF) begin n_fail++; $display("FAIL midrun_pre_oe: got %h expected ff", uio_oe); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL midrun_async_oe: got %h expected 00", uio_oe); end
    n_tests++; if (uio_out !== 8'h00) begin n_fail++; $display("FAIL midrun_async_uio_out: got %h expected 00", uio_out); end
    n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midrun_async_cnt: got %h expected 00", uo_out); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    n_tests++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL midrun_release_cnt: got %h expected 00", uo_out); end
    n_tests++; if (uio_oe !== 8'h00) begin n_fail++; $display("FAIL midrun_release_oe: got %h expected 00", uio_oe); end
  endtask

  initial begin
    test_reset();
    test_load_run_wrap();
    test_drive();
    test_sample();
    test_back_to_back_collision();
    test_random();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
